// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - rv32im shared widths and ID/EX control bundle type
package id_ex_pipe_reg_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int WB_EN_W     = 1;
  localparam int WB_SEL_W    = 2;
  localparam int MEM_RD_W    = 3;
  localparam int MEM_WR_W    = 2;
  localparam int BRANCH_W    = 3;
  localparam int ALUOP_W     = 5;
  localparam int OP1SEL_W    = 1;
  localparam int OP2SEL_W    = 1;
  localparam int BUBBLE_CNT_W = 32;

  typedef struct packed {
    logic [WB_EN_W-1:0]  wb_en;
    logic [WB_SEL_W-1:0] wb_sel;
    logic [MEM_RD_W-1:0] mem_rd;
    logic [MEM_WR_W-1:0] mem_wr;
    logic [BRANCH_W-1:0] branch;
    logic [ALUOP_W-1:0]  aluop;
    logic [OP1SEL_W-1:0] op1sel;
    logic [OP2SEL_W-1:0] op2sel;
  } ctrl_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - ID/EX boundary signals; master is the ID side, slave the pipe register
interface id_ex_pipe_reg_if;
  import id_ex_pipe_reg_pkg::*;

  logic                  hold;
  logic                  flush;
  logic                  bubble_in;

  logic [WB_EN_W-1:0]    wb_en_in;
  logic [WB_SEL_W-1:0]   wb_sel_in;
  logic [MEM_RD_W-1:0]   mem_rd_in;
  logic [MEM_WR_W-1:0]   mem_wr_in;
  logic [BRANCH_W-1:0]   branch_in;
  logic [ALUOP_W-1:0]    aluop_in;
  logic [OP1SEL_W-1:0]   op1sel_in;
  logic [OP2SEL_W-1:0]   op2sel_in;
  logic [XLEN-1:0]       pc_in;
  logic [XLEN-1:0]       rs1_data_in;
  logic [XLEN-1:0]       rs2_data_in;
  logic [XLEN-1:0]       imm_in;
  logic [REG_ADDR_W-1:0] rd_addr_in;
  logic [REG_ADDR_W-1:0] rs1_addr_in;
  logic [REG_ADDR_W-1:0] rs2_addr_in;

  logic [WB_EN_W-1:0]    wb_en_out;
  logic [WB_SEL_W-1:0]   wb_sel_out;
  logic [MEM_RD_W-1:0]   mem_rd_out;
  logic [MEM_WR_W-1:0]   mem_wr_out;
  logic [BRANCH_W-1:0]   branch_out;
  logic [ALUOP_W-1:0]    aluop_out;
  logic [OP1SEL_W-1:0]   op1sel_out;
  logic [OP2SEL_W-1:0]   op2sel_out;
  logic [XLEN-1:0]       pc_out;
  logic [XLEN-1:0]       rs1_data_out;
  logic [XLEN-1:0]       rs2_data_out;
  logic [XLEN-1:0]       imm_out;
  logic [REG_ADDR_W-1:0] rd_addr_out;
  logic [REG_ADDR_W-1:0] rs1_addr_out;
  logic [REG_ADDR_W-1:0] rs2_addr_out;
  logic                  valid_out;

  modport master (
    output hold, flush, bubble_in,
    output wb_en_in, wb_sel_in, mem_rd_in, mem_wr_in, branch_in, aluop_in, op1sel_in, op2sel_in,
    output pc_in, rs1_data_in, rs2_data_in, imm_in, rd_addr_in, rs1_addr_in, rs2_addr_in,
    input  wb_en_out, wb_sel_out, mem_rd_out, mem_wr_out, branch_out, aluop_out, op1sel_out, op2sel_out,
    input  pc_out, rs1_data_out, rs2_data_out, imm_out, rd_addr_out, rs1_addr_out, rs2_addr_out,
    input  valid_out
  );

  modport slave (
    input  hold, flush, bubble_in,
    input  wb_en_in, wb_sel_in, mem_rd_in, mem_wr_in, branch_in, aluop_in, op1sel_in, op2sel_in,
    input  pc_in, rs1_data_in, rs2_data_in, imm_in, rd_addr_in, rs1_addr_in, rs2_addr_in,
    output wb_en_out, wb_sel_out, mem_rd_out, mem_wr_out, branch_out, aluop_out, op1sel_out, op2sel_out,
    output pc_out, rs1_data_out, rs2_data_out, imm_out, rd_addr_out, rs1_addr_out, rs2_addr_out,
    output valid_out
  );

endinterface

// File: rtl/pipe_field_reg.sv
// rtl/pipe_field_reg.sv - one pipeline field: clear beats hold beats load, async reset to 0
module pipe_field_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             hold,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clear)
      q <= '0;
    else if (!hold)
      q <= d;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, squash and bubble insertion
// Optional bubble counter output enabled by ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  id_ex_pipe_reg_if.slave         bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

  ctrl_t ctrl_in;
  ctrl_t ctrl_d;

  assign ctrl_in = {bus.wb_en_in, bus.wb_sel_in, bus.mem_rd_in, bus.mem_wr_in,
                    bus.branch_in, bus.aluop_in, bus.op1sel_in, bus.op2sel_in};
  // A bubble keeps its data fields but must never carry live control into EX.
  assign ctrl_d  = bus.bubble_in ? '0 : ctrl_in;

  pipe_field_reg #(.WIDTH(WB_EN_W))  u_wb_en  (.clk, .rst_n, .d(ctrl_d.wb_en),  .hold(bus.hold), .clear(bus.flush), .q(bus.wb_en_out));
  pipe_field_reg #(.WIDTH(WB_SEL_W)) u_wb_sel (.clk, .rst_n, .d(ctrl_d.wb_sel), .hold(bus.hold), .clear(bus.flush), .q(bus.wb_sel_out));
  pipe_field_reg #(.WIDTH(MEM_RD_W)) u_mem_rd (.clk, .rst_n, .d(ctrl_d.mem_rd), .hold(bus.hold), .clear(bus.flush), .q(bus.mem_rd_out));
  pipe_field_reg #(.WIDTH(MEM_WR_W)) u_mem_wr (.clk, .rst_n, .d(ctrl_d.mem_wr), .hold(bus.hold), .clear(bus.flush), .q(bus.mem_wr_out));
  pipe_field_reg #(.WIDTH(BRANCH_W)) u_branch (.clk, .rst_n, .d(ctrl_d.branch), .hold(bus.hold), .clear(bus.flush), .q(bus.branch_out));
  pipe_field_reg #(.WIDTH(ALUOP_W))  u_aluop  (.clk, .rst_n, .d(ctrl_d.aluop),  .hold(bus.hold), .clear(bus.flush), .q(bus.aluop_out));
  pipe_field_reg #(.WIDTH(OP1SEL_W)) u_op1sel (.clk, .rst_n, .d(ctrl_d.op1sel), .hold(bus.hold), .clear(bus.flush), .q(bus.op1sel_out));
  pipe_field_reg #(.WIDTH(OP2SEL_W)) u_op2sel (.clk, .rst_n, .d(ctrl_d.op2sel), .hold(bus.hold), .clear(bus.flush), .q(bus.op2sel_out));

  pipe_field_reg #(.WIDTH(XLEN))       u_pc       (.clk, .rst_n, .d(bus.pc_in),       .hold(bus.hold), .clear(bus.flush), .q(bus.pc_out));
  pipe_field_reg #(.WIDTH(XLEN))       u_rs1_data (.clk, .rst_n, .d(bus.rs1_data_in), .hold(bus.hold), .clear(bus.flush), .q(bus.rs1_data_out));
  pipe_field_reg #(.WIDTH(XLEN))       u_rs2_data (.clk, .rst_n, .d(bus.rs2_data_in), .hold(bus.hold), .clear(bus.flush), .q(bus.rs2_data_out));
  pipe_field_reg #(.WIDTH(XLEN))       u_imm      (.clk, .rst_n, .d(bus.imm_in),      .hold(bus.hold), .clear(bus.flush), .q(bus.imm_out));
  pipe_field_reg #(.WIDTH(REG_ADDR_W)) u_rd_addr  (.clk, .rst_n, .d(bus.rd_addr_in),  .hold(bus.hold), .clear(bus.flush), .q(bus.rd_addr_out));
  pipe_field_reg #(.WIDTH(REG_ADDR_W)) u_rs1_addr (.clk, .rst_n, .d(bus.rs1_addr_in), .hold(bus.hold), .clear(bus.flush), .q(bus.rs1_addr_out));
  pipe_field_reg #(.WIDTH(REG_ADDR_W)) u_rs2_addr (.clk, .rst_n, .d(bus.rs2_addr_in), .hold(bus.hold), .clear(bus.flush), .q(bus.rs2_addr_out));

  pipe_field_reg #(.WIDTH(1)) u_valid (.clk, .rst_n, .d(~bus.bubble_in), .hold(bus.hold), .clear(bus.flush), .q(bus.valid_out));

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] cnt_q;
  logic                    bubble_load;

  // Same condition that drives valid_out to 0 at the edge: squash, or an unstalled bubble.
  assign bubble_load = bus.flush | (~bus.hold & bus.bubble_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (bubble_load && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   exp_cnt;

  id_ex_pipe_reg_if bus ();

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;
`endif

  id_ex_pipe_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  logic [161:0] all_out;
  assign all_out = {bus.wb_en_out, bus.wb_sel_out, bus.mem_rd_out, bus.mem_wr_out,
                    bus.branch_out, bus.aluop_out, bus.op1sel_out, bus.op2sel_out,
                    bus.pc_out, bus.rs1_data_out, bus.rs2_data_out, bus.imm_out,
                    bus.rd_addr_out, bus.rs1_addr_out, bus.rs2_addr_out, bus.valid_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.hold = 0; bus.flush = 0; bus.bubble_in = 0;
    bus.wb_en_in = 0; bus.wb_sel_in = 0; bus.mem_rd_in = 0; bus.mem_wr_in = 0;
    bus.branch_in = 0; bus.aluop_in = 0; bus.op1sel_in = 0; bus.op2sel_in = 0;
    bus.pc_in = 0; bus.rs1_data_in = 0; bus.rs2_data_in = 0; bus.imm_in = 0;
    bus.rd_addr_in = 0; bus.rs1_addr_in = 0; bus.rs2_addr_in = 0;
  endtask

  task automatic check_cnt(input string name);
`ifdef ID_EX_BUBBLE_CNT_EN
    n_vec++;
    if (bubble_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s: bubble_cnt=%0h expected %0h", name, bubble_cnt, exp_cnt);
    end
`else
    if (name.len() == 0) $display("empty counter check name");
`endif
  endtask

  task automatic test_reset;
    drive_idle();
    rst_n = 0;
    exp_cnt = 0;
    tick(); tick();
    n_vec++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: %h expected 0", all_out); end
    check_cnt("reset_cnt");
    #2 rst_n = 1;
    tick();
    n_vec++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h0) begin
      n_err++; $display("FAIL reset_resume: valid=%b pc=%h expected valid=1 pc=0", bus.valid_out, bus.pc_out);
    end
  endtask

  task automatic test_normal_load;
    drive_idle();
    bus.pc_in = 32'h0000_0040; bus.aluop_in = 5'b00011; bus.wb_en_in = 1;
    bus.wb_sel_in = 2'b10; bus.mem_rd_in = 3'b101; bus.branch_in = 3'b011;
    bus.op1sel_in = 1; bus.op2sel_in = 1;
    bus.rs1_data_in = 32'hDEAD_BEEF; bus.rs2_data_in = 32'h1234_5678; bus.imm_in = 32'hFFFF_FFF0;
    bus.rd_addr_in = 5'd3; bus.rs1_addr_in = 5'd17; bus.rs2_addr_in = 5'd31;
    tick();
    n_vec++;
    if (bus.pc_out !== 32'h40 || bus.aluop_out !== 5'b00011 || bus.valid_out !== 1'b1) begin
      n_err++; $display("FAIL load_main: pc=%h aluop=%b valid=%b expected 40 00011 1", bus.pc_out, bus.aluop_out, bus.valid_out);
    end
    n_vec++;
    if ({bus.wb_en_out, bus.wb_sel_out, bus.mem_rd_out, bus.mem_wr_out, bus.branch_out, bus.op1sel_out, bus.op2sel_out}
        !== {1'b1, 2'b10, 3'b101, 2'b00, 3'b011, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL load_ctrl: wb_en=%b wb_sel=%b mem_rd=%b mem_wr=%b branch=%b op1=%b op2=%b",
                        bus.wb_en_out, bus.wb_sel_out, bus.mem_rd_out, bus.mem_wr_out, bus.branch_out, bus.op1sel_out, bus.op2sel_out);
    end
    n_vec++;
    if (bus.rs1_data_out !== 32'hDEAD_BEEF || bus.rs2_data_out !== 32'h1234_5678 || bus.imm_out !== 32'hFFFF_FFF0 ||
        bus.rd_addr_out !== 5'd3 || bus.rs1_addr_out !== 5'd17 || bus.rs2_addr_out !== 5'd31) begin
      n_err++; $display("FAIL load_data: rs1=%h rs2=%h imm=%h rd=%0d a1=%0d a2=%0d",
                        bus.rs1_data_out, bus.rs2_data_out, bus.imm_out, bus.rd_addr_out, bus.rs1_addr_out, bus.rs2_addr_out);
    end
    check_cnt("load_cnt");
  endtask

  task automatic test_hold;
    drive_idle();
    bus.pc_in = 32'h44; bus.wb_en_in = 1;
    tick();
    bus.hold = 1; bus.pc_in = 32'h48; bus.flush = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.pc_out !== 32'h44 || bus.valid_out !== 1'b1 || bus.wb_en_out !== 1'b1) begin
        n_err++; $display("FAIL hold_cycle%0d: pc=%h valid=%b wb_en=%b expected 44 1 1", i, bus.pc_out, bus.valid_out, bus.wb_en_out);
      end
    end
    bus.hold = 0;
    tick();
    n_vec++;
    if (bus.pc_out !== 32'h48) begin n_err++; $display("FAIL hold_release: pc=%h expected 48", bus.pc_out); end
    check_cnt("hold_cnt");
  endtask

  task automatic test_flush_over_hold;
    drive_idle();
    bus.pc_in = 32'h100; bus.wb_en_in = 1; bus.rd_addr_in = 5'd9;
    tick();
    bus.hold = 1; bus.flush = 1;
    tick();
    exp_cnt++;
    n_vec++;
    if (all_out !== '0) begin n_err++; $display("FAIL flush_outputs: %h expected 0", all_out); end
    check_cnt("flush_cnt");
  endtask

  task automatic test_bubble;
    drive_idle();
    bus.bubble_in = 1; bus.mem_wr_in = 2'b10; bus.rd_addr_in = 5'd7;
    bus.wb_en_in = 1; bus.mem_rd_in = 3'b010; bus.aluop_in = 5'b10101; bus.pc_in = 32'h200;
    tick();
    exp_cnt++;
    n_vec++;
    if (bus.mem_wr_out !== 2'b00 || bus.valid_out !== 1'b0 || bus.rd_addr_out !== 5'd7) begin
      n_err++; $display("FAIL bubble_main: mem_wr=%b valid=%b rd=%0d expected 00 0 7", bus.mem_wr_out, bus.valid_out, bus.rd_addr_out);
    end
    n_vec++;
    if (bus.wb_en_out !== 1'b0 || bus.mem_rd_out !== 3'b000 || bus.aluop_out !== 5'b0 || bus.pc_out !== 32'h200) begin
      n_err++; $display("FAIL bubble_ctrl: wb_en=%b mem_rd=%b aluop=%b pc=%h expected 0 000 00000 200",
                        bus.wb_en_out, bus.mem_rd_out, bus.aluop_out, bus.pc_out);
    end
    check_cnt("bubble_cnt");
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs [3];
    logic [4:0]  ops [3];
    pcs = '{32'h300, 32'h304, 32'h308};
    ops = '{5'd1, 5'd30, 5'd17};
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = pcs[i]; bus.aluop_in = ops[i]; bus.mem_wr_in = 2'(i + 1);
      tick();
      n_vec++;
      if (bus.pc_out !== pcs[i] || bus.aluop_out !== ops[i] || bus.mem_wr_out !== 2'(i + 1) || bus.valid_out !== 1'b1) begin
        n_err++; $display("FAIL b2b_%0d: pc=%h aluop=%0d mem_wr=%0d valid=%b expected %h %0d %0d 1",
                          i, bus.pc_out, bus.aluop_out, bus.mem_wr_out, bus.valid_out, pcs[i], ops[i], i + 1);
      end
    end
    // A bubble arriving during a stall must neither land nor count.
    bus.hold = 1; bus.bubble_in = 1; bus.pc_in = 32'h30C;
    tick();
    n_vec++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h308 || bus.mem_wr_out !== 2'd3) begin
      n_err++; $display("FAIL hold_bubble: valid=%b pc=%h mem_wr=%0d expected 1 308 3", bus.valid_out, bus.pc_out, bus.mem_wr_out);
    end
    check_cnt("hold_bubble_cnt");
  endtask

  task automatic test_async_reset;
    drive_idle();
    bus.pc_in = 32'h80; bus.wb_en_in = 1; bus.mem_rd_in = 3'b001;
    tick();
    bus.hold = 1;
    tick();
    #2 rst_n = 0;
    #1;
    exp_cnt = 0;
    n_vec++;
    if (all_out !== '0) begin n_err++; $display("FAIL async_reset: %h expected 0", all_out); end
    check_cnt("async_reset_cnt");
    tick();
    #2 rst_n = 1;
    tick();
    n_vec++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset_discard: %h expected 0", all_out); end
    bus.hold = 0; bus.pc_in = 32'h90;
    tick();
    n_vec++;
    if (bus.pc_out !== 32'h90 || bus.valid_out !== 1'b1 || bus.wb_en_out !== 1'b1) begin
      n_err++; $display("FAIL post_reset_load: pc=%h valid=%b wb_en=%b expected 90 1 1", bus.pc_out, bus.valid_out, bus.wb_en_out);
    end
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_saturation;
    drive_idle();
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    check_cnt("sat_preload");
    bus.flush = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cnt = 32'hFFFF_FFFF;
      check_cnt("sat_flush");
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_cnt = 0;
    rst_n = 0;
    drive_idle();
    test_reset();
    test_normal_load();
    test_hold();
    test_flush_over_hold();
    test_bubble();
    test_back_to_back();
    test_async_reset();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have CLK  input  1  rising-edge clock for all state.
REQ-002 SHALL have RESETN  input  1  asynchronous, active-low reset.
REQ-003 SHALL have HOLD  input  1  stall; keep all stored fields (multi-cycle MUL/DIV, memory wait).
REQ-004 SHALL have FLUSH  input  1  squash; load a bubble (taken branch/jump).
REQ-005 SHALL have BUBBLE_IN  input  1  ID-stage bubble indicator (same signal that selects zeroed control in ID).
REQ-006 SHALL have control inputs WB_EN_IN 1, WB_SEL_IN 2, MEM_RD_IN 3, MEM_WR_IN 2, BRANCH_IN 3, ALUOP_IN 5, OP1SEL_IN 1, OP2SEL_IN 1, all inputs.
REQ-007 SHALL have data inputs PC_IN 32, RS1_DATA_IN 32, RS2_DATA_IN 32, IMM_IN 32, RD_ADDR_IN 5, RS1_ADDR_IN 5, RS2_ADDR_IN 5.
REQ-008 SHALL have a registered output for each control and data input, named with suffix _OUT and the same width.
REQ-009 SHALL have VALID_OUT  output  1  EX stage holds a real instruction.

Function
REQ-010 SHALL update state only on rising CLK edge while RESETN is high; priority FLUSH > HOLD > normal load.
REQ-011 SHALL, on normal load (FLUSH=0, HOLD=0), capture every input in one cycle; latency exactly 1 cycle.
REQ-012 SHALL set VALID_OUT to NOT BUBBLE_IN on normal load.
REQ-013 SHALL, on normal load with BUBBLE_IN=1, force all control outputs to 0, independent of control input values.
REQ-014 SHALL, on HOLD=1 and FLUSH=0, keep all outputs, including VALID_OUT, unchanged for as many cycles as HOLD is asserted.
REQ-015 SHALL, on FLUSH=1 (with or without HOLD), set all control outputs, all data outputs and VALID_OUT to 0 at that edge.
REQ-016 SHALL give control and VALID_OUT outputs no combinational path from any input; they are pure flops.
REQ-017 SHALL never present non-zero WB_EN_OUT, MEM_RD_OUT or MEM_WR_OUT while VALID_OUT=0.

Reset
REQ-018 SHALL, on RESETN low, immediately (asynchronously) clear every output, including VALID_OUT, to 0.
REQ-019 SHALL, on RESETN deassertion, resume at the next rising edge with the rules of REQ-010 to REQ-015.
REQ-020 SHALL, when reset asserts mid-HOLD, discard the held instruction; HOLD has no effect while RESETN is low.

Configuration
REQ-021 SHALL, with ID_EX_BUBBLE_CNT_EN defined, add output BUBBLE_CNT (32 bits): a saturating counter that increments by 1 on every edge where the loaded VALID_OUT becomes 0 through FLUSH or BUBBLE_IN, does not count during HOLD, holds at 0xFFFFFFFF, and is cleared by RESETN.
REQ-022 SHALL, without ID_EX_BUBBLE_CNT_EN, have no BUBBLE_CNT port and no counter logic; all other behaviour is identical.

Structure
REQ-023 SHALL take control-field widths (1,2,3,2,3,5,1,1), XLEN=32 and REG_ADDR_W=5 from the shared rv32im defines header; no widths are hard-coded locally.
REQ-024 SHALL build every field from one parameterized sub-module pipe_field_reg (WIDTH; inputs D, HOLD, CLEAR; async active-low reset to 0), one instance per field.
REQ-025 SHALL keep the bubble counter inside id_ex_pipe_reg under the macro guard, not in pipe_field_reg.

Verification
REQ-026 SHALL cover normal load: PC_IN=0x00000040, ALUOP_IN=5'b00011, WB_EN_IN=1, BUBBLE_IN=0 -> after 1 edge PC_OUT=0x00000040, ALUOP_OUT=5'b00011, VALID_OUT=1.
REQ-027 SHALL cover hold: load PC 0x44, then HOLD=1 for 3 cycles with PC_IN=0x48 -> PC_OUT stays 0x44 for all 3 cycles, then becomes 0x48 one edge after HOLD drops.
REQ-028 SHALL cover flush over hold: HOLD=1, FLUSH=1, WB_EN_IN=1 -> next edge all outputs 0, VALID_OUT=0; with counter enabled, BUBBLE_CNT increments by 1.
REQ-029 SHALL cover bubble: BUBBLE_IN=1, MEM_WR_IN=2'b10, RD_ADDR_IN=5'd7 -> MEM_WR_OUT=0, VALID_OUT=0, RD_ADDR_OUT=7.
REQ-030 SHALL cover async reset: with a valid instruction held, drive RESETN low between clock edges -> all outputs 0 before the next edge; BUBBLE_CNT=0.
REQ-031 SHALL cover counter saturation (macro defined): force the counter to 0xFFFFFFFE, then 3 flush cycles -> BUBBLE_CNT=0xFFFFFFFF and stays there.
